// File: rtl/ifetch_queue_pkg.sv
// ---------------------------------------------------------------------------
// ifetch_pkg
//
// Shared types and helpers for the instruction fetch queue.
//   ifq_entry_t    : one queued fetch, the PC together with the word it fetched
//   ifq_ptr_next() : modulo-depth pointer advance used by the wrap counters
//
// Optional feature macro used by the queue: IFETCH_QUEUE_BYPASS_EN.
// ---------------------------------------------------------------------------
package ifetch_pkg;

  // Default widths for the MIPS datapath.
  localparam int IFQ_ADDR_WIDTH    = 32;
  localparam int IFQ_INSTR_WIDTH   = 32;
  localparam int IFQ_DEPTH_DEFAULT = 4;

  // Widest pointer ever needed. The largest legal depth is 16, which needs 4 bits.
  localparam int IFQ_PTR_MAX_W = 4;

  typedef struct packed {
    logic [IFQ_ADDR_WIDTH-1:0]  pc;
    logic [IFQ_INSTR_WIDTH-1:0] instr;
  } ifq_entry_t;

  // Advance a pointer by one and wrap from depth-1 back to 0.
  // Depth need not be a power of two, so plain binary overflow is not enough.
  function automatic logic [IFQ_PTR_MAX_W-1:0] ifq_ptr_next(
    input logic [IFQ_PTR_MAX_W-1:0] ptr,
    input int unsigned              depth
  );
    if (32'(ptr) >= depth - 32'd1) begin
      return '0;
    end
    return ptr + IFQ_PTR_MAX_W'(1);
  endfunction

endpackage

// File: rtl/ifetch_queue_if.sv
// ---------------------------------------------------------------------------
// ifetch_queue_if
//
// Handshake bundle between the fetch side, the queue and the decode side.
//   in_valid / in_ready / in_pc / in_instr     : fetch -> queue
//   out_valid / out_ready / out_pc / out_instr : queue -> decode
//
// Modports:
//   master : the surrounding pipeline (fetch drives in_*, decode drives out_ready)
//   slave  : the queue itself
// ---------------------------------------------------------------------------
interface ifetch_queue_if
  import ifetch_pkg::*;
#(
  parameter int ADDR_WIDTH  = IFQ_ADDR_WIDTH,
  parameter int INSTR_WIDTH = IFQ_INSTR_WIDTH
);

  logic                   in_valid;
  logic                   in_ready;
  logic [ADDR_WIDTH-1:0]  in_pc;
  logic [INSTR_WIDTH-1:0] in_instr;

  logic                   out_valid;
  logic                   out_ready;
  logic [ADDR_WIDTH-1:0]  out_pc;
  logic [INSTR_WIDTH-1:0] out_instr;

  modport master (
    output in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_instr
  );

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_instr
  );

endinterface

// File: rtl/ifetch_queue_wrap_ctr.sv
// ---------------------------------------------------------------------------
// wrap_ctr
//
// Modulo-DEPTH pointer for the circular buffer. It counts 0..DEPTH-1 and
// wraps to 0. A clear returns it to 0 and wins over increment.
//
// Ports:
//   clk   : clock
//   rst   : asynchronous active-high reset, forces ptr to 0
//   clear : synchronous return to 0 (used on flush)
//   inc   : advance by one, with wrap
//   ptr   : current pointer value
// ---------------------------------------------------------------------------
module wrap_ctr
  import ifetch_pkg::*;
#(
  parameter  int DEPTH = IFQ_DEPTH_DEFAULT,
  localparam int W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  logic [W-1:0] ptr_next;

  // Shared wrap rule from the package. The pointer is widened to the
  // package's pointer width for the call and narrowed back afterwards.
  always_comb begin
    ptr_next = W'(ifq_ptr_next(IFQ_PTR_MAX_W'(ptr), DEPTH));
  end

  // Pointer register. Clear has priority, so a flush in the same cycle as
  // a push or pop still leaves the pointer at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (clear) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// ---------------------------------------------------------------------------
// ifetch_queue
//
// Instruction fetch queue between instruction memory and decode. Each
// fetched word is stored with the PC that addressed it in a small circular
// buffer. The head entry is presented to decode through a valid/ready
// handshake, so fetch can run ahead of a stalled decode stage. Flush drops
// everything on a branch or jump redirect.
//
// Parameters:
//   ADDR_WIDTH, INSTR_WIDTH : PC and instruction widths
//   DEPTH                   : number of entries, 2..16, any value in that range
//
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   flush    : synchronous discard of every entry, wins over push and pop
//   bus      : ifetch_queue_if.slave (in_* from fetch, out_* to decode)
//   count    : number of occupied entries
//
// Optional feature: IFETCH_QUEUE_BYPASS_EN. When this macro is defined, an
// empty queue passes an offered word straight to decode in the same cycle.
// If decode takes the word, it is never written. When the macro is
// undefined, there is no combinational path from in_* to out_*.
// ---------------------------------------------------------------------------
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter  int ADDR_WIDTH  = IFQ_ADDR_WIDTH,
  parameter  int INSTR_WIDTH = IFQ_INSTR_WIDTH,
  parameter  int DEPTH       = IFQ_DEPTH_DEFAULT,
  localparam int PTR_W       = $clog2(DEPTH),
  localparam int CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  ifetch_queue_if.slave    bus,
  output logic [CNT_W-1:0] count
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  pc;
    logic [INSTR_WIDTH-1:0] instr;
  } entry_t;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  entry_t             storage [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count_q;

  logic               not_empty;
  logic               has_space;
  logic               bypass_show;
  logic               bypass_take;
  logic               push;
  logic               pop;

  assign not_empty = (count_q != '0);
  assign has_space = (count_q < DEPTH_C);

`ifdef IFETCH_QUEUE_BYPASS_EN
  // The offered word is shown directly on the output only when nothing older
  // is queued, so ordering is kept. If decode also accepts it, the word
  // passes through and never touches storage.
  assign bypass_show = !not_empty && bus.in_valid && !flush && !rst;
  assign bypass_take = bypass_show && bus.out_ready;
`else
  assign bypass_show = 1'b0;
  assign bypass_take = 1'b0;
`endif

  // Fullness comes only from the occupancy count, never from out_ready.
  // A pop in the same cycle therefore cannot make room for a push.
  assign push = bus.in_valid && has_space && !flush && !rst && !bypass_take;
  assign pop  = not_empty && bus.out_ready && !flush;

  assign bus.in_ready  = has_space && !rst;
  assign bus.out_valid = not_empty || bypass_show;
  assign bus.out_pc    = bypass_show ? bus.in_pc    : storage[rd_ptr].pc;
  assign bus.out_instr = bypass_show ? bus.in_instr : storage[rd_ptr].instr;
  assign count         = count_q;

  wrap_ctr #(.DEPTH(DEPTH)) u_wr_ctr (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .inc   (push),
    .ptr   (wr_ptr)
  );

  wrap_ctr #(.DEPTH(DEPTH)) u_rd_ctr (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .inc   (pop),
    .ptr   (rd_ptr)
  );

  // Entry storage. Reset zeroes every slot so the head reads as 0 out of
  // reset. Flush only moves the pointers, because stale slots are never
  // presented while count is zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        storage[i] <= '0;
      end
    end else if (push) begin
      storage[wr_ptr] <= {bus.in_pc, bus.in_instr};
    end
  end

  // Occupancy register. A push and a pop in the same cycle cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (flush) begin
      count_q <= '0;
    end else if (push && !pop) begin
      count_q <= count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// ---------------------------------------------------------------------------
// tb_ifetch_queue
//
// Drives two queues: dut_a with DEPTH=4 and dut_b with DEPTH=3. A reference
// model (a queue of ifq_entry_t) tracks dut_a and predicts its outputs every
// cycle. dut_b is checked against the expected ordered PC stream.
// IFETCH_QUEUE_BYPASS_EN selects which output timing is expected.
// ---------------------------------------------------------------------------
module tb_ifetch_queue;
  import ifetch_pkg::*;

  localparam int DEPTH_A = 4;
  localparam int DEPTH_B = 3;

`ifdef IFETCH_QUEUE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_a;
  logic        flush_b;
  logic [2:0]  count_a;
  logic [1:0]  count_b;

  int          vectors     = 0;
  int          miscompares = 0;

  ifq_entry_t  model_q [$];
  logic [31:0] popped_pcs [$];

  ifetch_queue_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32)) bus_a ();
  ifetch_queue_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32)) bus_b ();

  ifetch_queue #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .DEPTH(DEPTH_A)) dut_a (
    .clk   (clk),
    .rst   (rst),
    .flush (flush_a),
    .bus   (bus_a),
    .count (count_a)
  );

  ifetch_queue #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .DEPTH(DEPTH_B)) dut_b (
    .clk   (clk),
    .rst   (rst),
    .flush (flush_b),
    .bus   (bus_b),
    .count (count_b)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One cycle on dut_a. Inputs are applied just after a rising edge. Outputs
  // are checked against the model before the next edge. The model then
  // applies the queue rules for that edge. The task returns whether the
  // offered word was taken.
  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                               input logic ordy, input logic fl, output logic accepted);
    int          sz;
    logic        exp_rdy;
    logic        byp;
    logic        exp_ov;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    ifq_entry_t  junk;

    sz = model_q.size();
    bus_a.in_valid  = v;
    bus_a.in_pc     = pc;
    bus_a.in_instr  = instr;
    bus_a.out_ready = ordy;
    flush_a         = fl;
    #1;
    exp_rdy   = (sz < DEPTH_A);
    byp       = BYPASS && (sz == 0) && v && !fl;
    exp_ov    = (sz != 0) || byp;
    exp_pc    = '0;
    exp_instr = '0;
    if (exp_ov) begin
      exp_pc    = byp ? pc    : model_q[0].pc;
      exp_instr = byp ? instr : model_q[0].instr;
    end
    checkOutput("count", 32'(count_a), 32'(sz));
    checkOutput("in_ready", 32'(bus_a.in_ready), 32'(exp_rdy));
    checkOutput("out_valid", 32'(bus_a.out_valid), 32'(exp_ov));
    if (exp_ov) begin
      checkOutput("out_pc", bus_a.out_pc, exp_pc);
      checkOutput("out_instr", bus_a.out_instr, exp_instr);
    end
    if (bus_a.out_valid && ordy && !fl) popped_pcs.push_back(bus_a.out_pc);
    @(posedge clk);
    accepted = 1'b0;
    if (fl) begin
      model_q.delete();
    end else if (byp && ordy) begin
      accepted = 1'b1;
    end else begin
      if (sz != 0 && ordy) junk = model_q.pop_front();
      if (v && exp_rdy) begin
        model_q.push_back('{pc: pc, instr: instr});
        accepted = 1'b1;
      end
    end
    #1;
  endtask

  initial begin
    logic        acc;
    logic        pend;
    logic        v;
    logic        ordy;
    logic        fl;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] instr10;
    int          hits;
    int          nxt_in;
    int          nxt_out;

    rst = 1'b1;
    flush_a = 1'b0; flush_b = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.in_pc = '0; bus_a.in_instr = '0; bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_pc = '0; bus_b.in_instr = '0; bus_b.out_ready = 1'b0;

    // Values held during reset
    #12;
    checkOutput("rst_in_ready", 32'(bus_a.in_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
    checkOutput("rst_count", 32'(count_a), 32'd0);
    checkOutput("rst_out_pc", bus_a.out_pc, 32'd0);
    checkOutput("rst_out_instr", bus_a.out_instr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_in_ready", 32'(bus_a.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Fill to full with decode stalled, then offer a fifth word
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'(i * 4), $urandom, 1'b0, 1'b0, acc);
    instr10 = $urandom;
    applyStimulus(1'b1, 32'h10, instr10, 1'b0, 1'b0, acc);
    checkOutput("full_count", 32'(count_a), 32'd4);
    checkOutput("full_in_ready", 32'(bus_a.in_ready), 32'd0);

    // Drain while 0x10 waits for a free slot
    popped_pcs.delete();
    pend = 1'b1;
    for (int c = 0; c < 8; c++) begin
      applyStimulus(pend, 32'h10, instr10, 1'b1, 1'b0, acc);
      if (acc) pend = 1'b0;
    end
    checkOutput("drain_len", 32'(popped_pcs.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < popped_pcs.size()) checkOutput("drain_order", popped_pcs[i], 32'(i * 4));
    end

    // Flush with three held entries, while a push and a pop are both offered
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h20 + 32'(i * 4), $urandom, 1'b0, 1'b0, acc);
    popped_pcs.delete();
    applyStimulus(1'b1, 32'h40, $urandom, 1'b1, 1'b1, acc);
    checkOutput("flush_count", 32'(count_a), 32'd0);
    checkOutput("flush_out_valid", 32'(bus_a.out_valid), 32'd0);
    for (int c = 0; c < 3; c++) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, acc);
    hits = 0;
    foreach (popped_pcs[i]) if (popped_pcs[i] == 32'h40) hits++;
    checkOutput("flush_no_0x40", 32'(hits), 32'd0);

    // Asynchronous reset between edges with two entries held
    applyStimulus(1'b1, 32'h50, $urandom, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 32'h54, $urandom, 1'b0, 1'b0, acc);
    bus_a.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_out_valid", 32'(bus_a.out_valid), 32'd0);
    checkOutput("arst_count", 32'(count_a), 32'd0);
    checkOutput("arst_in_ready", 32'(bus_a.in_ready), 32'd0);
    model_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("arst_release_in_ready", 32'(bus_a.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Offer on an empty queue while decode is ready
    popped_pcs.delete();
    applyStimulus(1'b1, 32'h80, $urandom, 1'b1, 1'b0, acc);
    for (int c = 0; c < 2; c++) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, acc);
    checkOutput("bypass_popped", 32'(popped_pcs.size()), 32'd1);
    if (popped_pcs.size() > 0) checkOutput("bypass_pc", popped_pcs[0], 32'h80);

    // Random traffic: light then heavy decode readiness, with occasional flushes
    pend = 1'b0;
    v = 1'b0; pc = '0; instr = '0;
    for (int c = 0; c < 300; c++) begin
      if (!pend) begin
        v     = 1'($urandom_range(0, 1));
        pc    = 32'($urandom_range(0, 1023)) << 2;
        instr = $urandom;
      end
      ordy = ($urandom_range(0, 99) < ((c < 150) ? 30 : 80));
      fl   = ($urandom_range(0, 29) == 0);
      applyStimulus(v, pc, instr, ordy, fl, acc);
      pend = v && !acc && !fl;
    end
    bus_a.in_valid = 1'b0;

    // dut_b (DEPTH 3): stream ten words with decode always ready
    nxt_in = 0;
    nxt_out = 0;
    for (int c = 0; c < 40 && nxt_out < 10; c++) begin
      bus_b.in_valid  = (nxt_in < 10);
      bus_b.in_pc     = 32'(nxt_in * 4);
      bus_b.in_instr  = ~32'(nxt_in * 4);
      bus_b.out_ready = 1'b1;
      #1;
      if (bus_b.out_valid) begin
        checkOutput("b_pc", bus_b.out_pc, 32'(nxt_out * 4));
        checkOutput("b_instr", bus_b.out_instr, ~32'(nxt_out * 4));
        nxt_out++;
      end
      if (bus_b.in_valid && bus_b.in_ready) nxt_in++;
      @(posedge clk);
      #1;
    end
    bus_b.in_valid = 1'b0;
    checkOutput("b_total", 32'(nxt_out), 32'd10);
    checkOutput("b_count_end", 32'(count_b), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction fetch queue between instruction memory and the decode stage of the MIPS pipeline. Each fetched word is captured together with the PC that addressed it, held in a small circular buffer, and presented to decode over a valid/ready handshake. Fetch can therefore run ahead of a stalled decode stage. A flush input discards all queued words on a branch or jump redirect.

## Interface
Parameters:
- ADDR_WIDTH, 32, PC width.
- INSTR_WIDTH, 32, instruction word width.
- DEPTH, 4, number of entries. Legal range is 2..16; DEPTH need not be a power of two.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  fetch side presents a word this cycle.
- in_ready  out  1  queue accepts the presented word.
- in_pc  in  ADDR_WIDTH  PC of the presented word.
- in_instr  in  INSTR_WIDTH  presented instruction word.
- out_valid  out  1  head entry is available to decode.
- out_ready  in  1  decode consumes the head entry this cycle.
- out_pc  out  ADDR_WIDTH  PC of the head entry.
- out_instr  out  INSTR_WIDTH  instruction word of the head entry.
- flush  in  1  synchronous discard of all entries.
- count  out  $clog2(DEPTH+1)  number of occupied entries.

## Operation
- Storage: DEPTH entries of {pc, instr}. wr_ptr and rd_ptr each wrap from DEPTH-1 to 0. An explicit count register holds occupancy; full and empty are never derived from pointer equality.
- Push occurs when in_valid && in_ready. The entry is written at wr_ptr, wr_ptr advances, and count increments.
- Pop occurs when out_valid && out_ready. rd_ptr advances and count decrements.
- A simultaneous push and pop leaves count unchanged and advances both pointers.
- in_ready = (count < DEPTH) && !rst. A pop in the same cycle does not free a slot for the push, so a full queue never accepts.
- out_valid = (count != 0). out_pc and out_instr are driven combinationally from storage[rd_ptr].
- Upstream must hold in_pc and in_instr stable while in_valid && !in_ready.
- While out_valid && !out_ready, out_pc and out_instr remain stable.
- Flush has priority over push and pop. In the next cycle count = 0, rd_ptr = wr_ptr = 0, and out_valid = 0. A push offered during the flush cycle is dropped even if in_ready = 1.
- Reset mid-operation: all state clears immediately and asynchronously. Contents in flight are lost.
- Reset values: count = 0, pointers = 0, out_valid = 0, in_ready = 0 while rst is asserted, out_pc = 0, out_instr = 0. Storage resets to zero.

## Timing
- Latency from push to out_valid is 1 cycle when the queue is empty. A word pushed at edge N is visible after edge N.
- Throughput is one push and one pop per cycle.
- in_ready rises the cycle after the pop that takes count from DEPTH to DEPTH-1.
- in_ready is 1 in the first cycle after rst deasserts.
- There are no combinational paths from in_* to out_*, or from out_ready to in_ready. The only exception is under the bypass macro described below.

## Configuration
- Macro: IFETCH_QUEUE_BYPASS_EN.
- Defined: when count == 0, in_valid = 1 and flush = 0, out_valid = 1 in the same cycle, with out_pc = in_pc and out_instr = in_instr.
  - If out_ready is also 1, the word passes through, nothing is written, and count stays 0.
  - If out_ready is 0, the word is pushed normally.
  - Empty-queue latency becomes 0 cycles.
- Not defined: no combinational in-to-out path exists, and latency is always at least 1 cycle.

## Structure
- Package ifetch_pkg holds:
  - typedef struct packed {pc, instr} ifq_entry_t.
  - IFQ_DEPTH_DEFAULT = 4.
  - function ifq_ptr_next(ptr, depth) implementing the wrap rule.
- Sub-module wrap_ctr implements a parameterised modulo-DEPTH pointer with increment and clear inputs. It is instantiated twice, once for wr_ptr and once for rd_ptr.

## Test plan
- Reset, then push PCs 0x00/0x04/0x08/0x0C with out_ready = 0.
  - After 4 pushes, count = 4 and in_ready = 0.
  - A 5th offer with in_pc = 0x10 is not accepted and the queue contents are unchanged.
- From full, hold out_ready = 1 and in_valid = 1.
  - Pops are in order 0x00, 0x04, and so on.
  - in_ready returns one cycle after the first pop.
  - 0x10 is enqueued and later emerges after 0x0C.
- DEPTH = 3: stream 10 words with out_ready = 1.
  - Pointers wrap correctly.
  - The output PC sequence is 0x00..0x24 with no gaps or duplicates.
- Hold 3 entries, then assert flush together with in_valid (in_pc = 0x40) and out_ready.
  - In the next cycle count = 0 and out_valid = 0.
  - 0x40 is never output.
- Assert rst asynchronously between clock edges with 2 entries held.
  - out_valid = 0, count = 0 and in_ready = 0 immediately.
  - in_ready = 1 in the first cycle after release.
- With IFETCH_QUEUE_BYPASS_EN, on an empty queue, in_valid = 1 (in_pc = 0x80) and out_ready = 1.
  - out_valid = 1 in the same cycle with out_pc = 0x80, and count stays 0.
  - Without the macro, out_valid = 1 one cycle later.
